fpga_config_loader: RTL
=======================

Name: fpga_config_loader

Overview:
- Sequences configuration of the fabric's serial CRAM chain.
- Accepts the bitstream as parallel words over a valid/ready handshake and serializes them MSB-first onto the chain's config_en/config_data_in pair.
- Counts exactly CHAIN_LEN bits, then reports done.
- Holds the fabric logic reset (le_nrst) asserted for the whole load, releasing it only after a successful load.

Parameters:
- CHAIN_LEN, 4096: total CRAM bits in the chain, summed over all cells.
- WORD_WIDTH, 32: bitstream word width.
- CNT_W, $clog2(CHAIN_LEN+1): width of the bit counter.

Ports:
- clk  in  1  system clock; the same clock that drives the CRAM chain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE, DONE or ERROR.
- abort  in  1  one-cycle pulse that cancels a load in progress.
- word_in  in  WORD_WIDTH  bitstream word, MSB shifted first.
- word_valid  in  1  word_in is valid.
- word_ready  out  1  loader accepts word_in this cycle.
- cfg_en  out  1  to the chain's config_en; high only on cycles carrying a real bit.
- cfg_data  out  1  to the chain's config_data_in.
- le_nrst_out  out  1  active-low fabric logic reset.
- busy  out  1  load in progress.
- done  out  1  level; last load completed successfully.
- error  out  1  level; last load failed (CRC only).

Behaviour:
- Reset (async, all regs):
  - state=IDLE; word_ready=0; cfg_en=0; cfg_data=0; le_nrst_out=0; busy=0; done=0; error=0.
  - Bit counter and shift register are cleared.
- IDLE:
  - On start: go to LOAD, busy=1, done=0, error=0, counter=0, le_nrst_out=0.
- LOAD:
  - word_ready=1, cfg_en=0.
  - On word_valid&word_ready: latch word_in into the shift register and go to SHIFT.
  - The number of bits to shift is min(WORD_WIDTH, CHAIN_LEN-counter).
  - Without valid, stay in LOAD; the chain holds its contents (cfg_en low).
- SHIFT:
  - Each cycle: cfg_en=1 and cfg_data=shift register MSB (registered outputs).
  - Shift register shifts left; counter increments.
  - On the cycle counter reaches CHAIN_LEN: go to FINISH. Remaining low bits of a partial final word are discarded.
  - Otherwise, when the word's bits are exhausted, return to LOAD.
  - Per full word: 1 accept cycle + WORD_WIDTH shift cycles.
- FINISH (one cycle):
  - cfg_en=0.
  - Go to DONE: done=1, busy=0, le_nrst_out=1 from the next cycle.
- DONE / ERROR:
  - Outputs hold.
  - start re-enters LOAD: done, error, le_nrst_out and counter cleared.
- abort, in any busy state:
  - Next cycle: IDLE, cfg_en=0, word_ready=0, busy=0, done=0, le_nrst_out stays 0.
  - The partially loaded chain is left as-is.
- start while busy: ignored. abort in IDLE/DONE/ERROR: ignored.
- Simultaneous start and abort in DONE: start wins.
- cfg_en never asserts outside SHIFT.
- Total cfg_en-high cycles per successful load = CHAIN_LEN exactly.

Optional Feature:
- Macro: FPGA_CFG_CRC_EN.
- With the macro defined:
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no reflection, no xorout) is computed over every bit driven with cfg_en=1.
  - After the final bit, state CRC_LOAD: word_ready=1, cfg_en=0, and one more word is accepted. Its low 16 bits are the expected CRC.
  - Next cycle: on match, DONE as above. On mismatch, ERROR: error=1, busy=0, le_nrst_out stays 0.
  - abort during CRC_LOAD behaves as in other busy states.
- Without the macro:
  - No CRC logic and no CRC_LOAD state.
  - error is tied to 0.

Test Plan (CHAIN_LEN=40, WORD_WIDTH=16):
- Reset mid-SHIFT: assert rst with cfg_en=1 -> same cycle, cfg_en=0, le_nrst_out=0, busy=0; a new start reloads from bit 0.
- Full load, valid always high, words 0xA5F0, 0x1234, 0xC3xx -> exactly 40 cfg_en cycles; cfg_data sequence = 1010010111110000, 0001001000110100, 11000011; done=1 and le_nrst_out=1 two cycles after the 40th bit; low byte of the third word is never shifted.
- Handshake stall: word_valid dropped for 5 cycles between words 1 and 2 -> cfg_en=0 for those cycles; same 40-bit sequence, 5 cycles later.
- Abort after 20 bits -> next cycle busy=0, cfg_en=0, done=0, le_nrst_out=0; start then accepts word 1 again with counter=0.
- Start pulsed while busy -> ignored; bit count and sequence are unchanged.
- (FPGA_CFG_CRC_EN) Load as above, then send the correct CRC word -> done=1, error=0. Repeat with CRC^0x0001 -> error=1, done=0, le_nrst_out=0.

Source files
------------

// File: rtl/fpga_config_loader.sv
// Serial CRAM chain configuration loader: words in over valid/ready, bits out MSB-first.
// Optional CRC-16-CCITT bitstream check enabled by defining FPGA_CFG_CRC_EN.
module fpga_config_loader #(
    parameter int CHAIN_LEN  = 4096,
    parameter int WORD_WIDTH = 32,
    parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  cfg_en,
    output logic                  cfg_data,
    output logic                  le_nrst_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        FINISH,
        DONE,
        ERROR,
        CRC_LOAD
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [WORD_WIDTH-1:0] sr;
    logic [WORD_WIDTH-1:0] sr_nx;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nx;
    logic [BIT_W-1:0]      bidx;
    logic [BIT_W-1:0]      bidx_nx;
    logic                  accept;

    logic ready_nx;
    logic en_nx;
    logic data_nx;
    logic nrst_nx;
    logic busy_nx;
    logic done_nx;

    assign accept = word_valid & word_ready;

`ifdef FPGA_CFG_CRC_EN
    logic [15:0] crc;
    logic [15:0] crc_nx;
    logic [15:0] crc_step;
    logic        crc_fb;
    logic        err_nx;
    logic        err_q;

    // CRC advances on exactly the bit currently presented with cfg_en high
    assign crc_fb   = crc[15] ^ sr[WORD_WIDTH-1];
    assign crc_step = {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
    assign error    = err_q;
`else
    assign error = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            bidx        <= '0;
            word_ready  <= 1'b0;
            cfg_en      <= 1'b0;
            cfg_data    <= 1'b0;
            le_nrst_out <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef FPGA_CFG_CRC_EN
            crc         <= 16'hFFFF;
            err_q       <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            sr          <= sr_nx;
            cnt         <= cnt_nx;
            bidx        <= bidx_nx;
            word_ready  <= ready_nx;
            cfg_en      <= en_nx;
            cfg_data    <= data_nx;
            le_nrst_out <= nrst_nx;
            busy        <= busy_nx;
            done        <= done_nx;
`ifdef FPGA_CFG_CRC_EN
            crc         <= crc_nx;
            err_q       <= err_nx;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        bidx_nx  = bidx;
`ifdef FPGA_CFG_CRC_EN
        crc_nx   = crc;
`endif
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nx = LOAD;
                    cnt_nx   = '0;
`ifdef FPGA_CFG_CRC_EN
                    crc_nx   = 16'hFFFF;
`endif
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (accept) begin
                    sr_nx    = word_in;
                    bidx_nx  = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    sr_nx  = sr << 1;
                    cnt_nx = cnt + 1'b1;
`ifdef FPGA_CFG_CRC_EN
                    crc_nx = crc_step;
`endif
                    // Chain end takes priority: leftover low bits are dropped
                    if (cnt_nx == CNT_W'(CHAIN_LEN)) begin
`ifdef FPGA_CFG_CRC_EN
                        state_nx = CRC_LOAD;
`else
                        state_nx = FINISH;
`endif
                    end else if (bidx == BIT_W'(WORD_WIDTH - 1)) begin
                        state_nx = LOAD;
                    end else begin
                        bidx_nx = bidx + 1'b1;
                    end
                end
            end
            FINISH: begin
                state_nx = abort ? IDLE : DONE;
            end
`ifdef FPGA_CFG_CRC_EN
            CRC_LOAD: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (accept) begin
                    state_nx = (word_in[15:0] == crc) ? DONE : ERROR;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output logic, decoded from the upcoming state so every output is a flop
    always_comb begin
        ready_nx = (state_nx == LOAD) || (state_nx == CRC_LOAD);
        en_nx    = (state_nx == SHIFT);
        data_nx  = en_nx ? sr_nx[WORD_WIDTH-1] : 1'b0;
        busy_nx  = (state_nx == LOAD) || (state_nx == SHIFT) ||
                   (state_nx == FINISH) || (state_nx == CRC_LOAD);
        done_nx  = (state_nx == DONE);
        nrst_nx  = (state_nx == DONE);
`ifdef FPGA_CFG_CRC_EN
        err_nx   = (state_nx == ERROR);
`endif
    end

endmodule
